// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared types and constants for the video-RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int VRAM_AW = 14;
    localparam int VRAM_DW = 8;
    localparam int RETRY_W = 4;

    // Value of mem_a[14] for each screen bank
    localparam logic c_BANK_MAIN   = 1'b0;
    localparam logic c_BANK_SHADOW = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vram_rd_tag.sv
`default_nettype none
// ============================================================================
// Module      : vram_rd_tag
// Description : MEM_LAT-deep tag line marking each read slot as video or CPU;
//               the last tap strobes capture of mem_q for the tagged requester.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_rd_tag #(
    parameter int MEM_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_vidIssue,
    input  logic i_cpuRdIssue,
    output logic o_vidCap,
    output logic o_cpuCap
);

    // Tap 0 is the slot being addressed now; tap k is the slot addressed k clocks ago
    logic [1:0] w_tap [MEM_LAT];

    assign w_tap[0] = {i_vidIssue, i_cpuRdIssue};

    for (genvar i = 1; i < MEM_LAT; i++) begin : g_stage
        logic [1:0] r_stage;
        always_ff @(posedge clock) begin
            if (reset) begin
                r_stage <= 2'b00;
            end else begin
                r_stage <= w_tap[i-1];
            end
        end
        assign w_tap[i] = r_stage;
    end

    assign o_vidCap = w_tap[MEM_LAT-1][1];
    assign o_cpuCap = w_tap[MEM_LAT-1][0];

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares the video SRAM port between display fetch (absolute
//               priority) and the Z80 bus. Define VRAM_SHADOW_SCREEN_EN to
//               enable the second (shadow) screen bank.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               vid_rd,
    input  logic               vid_cn,
    input  logic [12:0]        vid_a,
    output logic [VRAM_DW-1:0] vid_q,
    output logic               vid_qv,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [VRAM_AW-1:0] cpu_a,
    input  logic               cpu_bank,
    input  logic [VRAM_DW-1:0] cpu_d,
    output logic [VRAM_DW-1:0] cpu_q,
    output logic               cpu_ack,
    output logic               cpu_wait,
    input  logic               screen_sel,
    output logic [VRAM_AW:0]   mem_a,
    output logic               mem_we,
    output logic [VRAM_DW-1:0] mem_d,
    input  logic [VRAM_DW-1:0] mem_q
);

    state_t             r_state;
    state_t             w_next;
    logic               r_cpuAck;
    logic               r_vidQv;
    logic [VRAM_DW-1:0] r_vidQ;
    logic [VRAM_DW-1:0] r_cpuQ;
    logic [VRAM_AW:0]   r_memA;
    logic [VRAM_AW:0]   w_memA;
    logic [RETRY_W-1:0] r_retryCnt;
    logic               w_vbank;
    logic               w_cpuBank;
    logic               w_inAcc;
    logic               w_cpuIssue;
    logic               w_vidCap;
    logic               w_cpuCap;

`ifdef VRAM_SHADOW_SCREEN_EN
    assign w_vbank   = screen_sel ? c_BANK_SHADOW : c_BANK_MAIN;
    assign w_cpuBank = cpu_bank   ? c_BANK_SHADOW : c_BANK_MAIN;
`else
    logic w_unusedBank;
    assign w_unusedBank = screen_sel ^ cpu_bank;
    assign w_vbank      = c_BANK_MAIN;
    assign w_cpuBank    = c_BANK_MAIN;
`endif

    assign w_inAcc    = (r_state == ACC);
    assign w_cpuIssue = w_inAcc & ~vid_rd;

    vram_rd_tag #(
        .MEM_LAT (MEM_LAT)
    ) u_rd_tag (
        .clock        (clock),
        .reset        (reset),
        .i_vidIssue   (vid_rd),
        .i_cpuRdIssue (w_cpuIssue & ~cpu_wr),
        .o_vidCap     (w_vidCap),
        .o_cpuCap     (w_cpuCap)
    );

    // Video wins the port in any clock it strobes; an idle bus keeps the last address
    always_comb begin
        w_memA = r_memA;
        if (vid_rd) begin
            w_memA = {w_vbank, 1'b0, vid_a};
        end else if (w_inAcc) begin
            w_memA = {w_cpuBank, cpu_a};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cpu_req && !vid_cn && !vid_rd && !r_cpuAck) begin
                    w_next = ACC;
                end
            end
            ACC: begin
                if (!vid_rd) begin
                    w_next = (cpu_wr || MEM_LAT == 1) ? DONE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (w_cpuCap) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cpuAck   <= 1'b0;
            r_vidQv    <= 1'b0;
            r_vidQ     <= '0;
            r_cpuQ     <= '0;
            r_memA     <= '0;
            r_retryCnt <= '0;
        end else begin
            r_state  <= w_next;
            r_cpuAck <= (w_next == DONE);
            r_vidQv  <= w_vidCap;
            r_memA   <= w_memA;
            if (w_vidCap) begin
                r_vidQ <= mem_q;
            end
            if (w_cpuCap) begin
                r_cpuQ <= mem_q;
            end
            if (w_inAcc && vid_rd && r_retryCnt != '1) begin
                r_retryCnt <= r_retryCnt + 1'b1;
            end
        end
    end

    // Reset gates the strobe combinationally so an in-flight write is dropped
    assign mem_we   = w_cpuIssue & cpu_wr & ~reset;
    assign mem_a    = w_memA;
    assign mem_d    = cpu_d;
    assign vid_q    = r_vidQ;
    assign vid_qv   = r_vidQv;
    assign cpu_q    = r_cpuQ;
    assign cpu_ack  = r_cpuAck;
    assign cpu_wait = cpu_req & ~r_cpuAck;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed scoreboard bench for vram_arbiter with an SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int MEM_LAT = 2;

    logic        clock;
    logic        reset;
    logic        vid_rd;
    logic        vid_cn;
    logic [12:0] vid_a;
    logic [7:0]  vid_q;
    logic        vid_qv;
    logic        cpu_req;
    logic        cpu_wr;
    logic [13:0] cpu_a;
    logic        cpu_bank;
    logic [7:0]  cpu_d;
    logic [7:0]  cpu_q;
    logic        cpu_ack;
    logic        cpu_wait;
    logic        screen_sel;
    logic [14:0] mem_a;
    logic        mem_we;
    logic [7:0]  mem_d;
    logic [7:0]  mem_q;

    vram_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .vid_rd     (vid_rd),
        .vid_cn     (vid_cn),
        .vid_a      (vid_a),
        .vid_q      (vid_q),
        .vid_qv     (vid_qv),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_a      (cpu_a),
        .cpu_bank   (cpu_bank),
        .cpu_d      (cpu_d),
        .cpu_q      (cpu_q),
        .cpu_ack    (cpu_ack),
        .cpu_wait   (cpu_wait),
        .screen_sel (screen_sel),
        .mem_a      (mem_a),
        .mem_we     (mem_we),
        .mem_d      (mem_d),
        .mem_q      (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // SRAM model: data for an address driven in clock t is on mem_q in clock t+MEM_LAT-1
    logic [7:0] ram [32768];
    logic [7:0] ramQ;
    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
        ram[15'h0123] = 8'h3C;
        ram[15'h0020] = 8'h81;
        ram[15'h0021] = 8'h7E;
        ram[15'h0456] = 8'h5A;
        ram[15'h0010] = 8'h66;
        ram[15'h0000] = 8'h11;
        ram[15'h4000] = 8'h22;
        forever begin
            @(posedge clock);
            ramQ <= ram[mem_a];
            if (mem_we === 1'b1) ram[mem_a] <= mem_d;
        end
    end
    assign mem_q = (MEM_LAT == 1) ? ram[mem_a] : ramQ;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed { logic [31:0] cyc; logic [7:0] d; } vidExp_t;
    typedef struct packed { logic [31:0] cyc; logic rd; logic [7:0] d; } cpuExp_t;
    typedef struct packed { logic [31:0] cyc; logic [14:0] a; logic [7:0] d; } wrExp_t;

    vidExp_t vidQ [$];
    cpuExp_t cpuQ [$];
    wrExp_t  wrQ  [$];
    vidExp_t ve;
    cpuExp_t ce;
    wrExp_t  we;
    logic    monEn = 1'b0;

    always @(negedge clock) begin
        if (monEn) begin
            if (vid_qv === 1'b1) begin
                if (vidQ.size() == 0) check("vid_qv_unexpected", 32'(vid_qv), 32'd0);
                else begin
                    ve = vidQ.pop_front();
                    check("vid_qv_cycle", 32'(cyc), ve.cyc);
                    check("vid_q", 32'(vid_q), 32'(ve.d));
                end
            end
            if (cpu_ack === 1'b1) begin
                if (cpuQ.size() == 0) check("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
                else begin
                    ce = cpuQ.pop_front();
                    check("cpu_ack_cycle", 32'(cyc), ce.cyc);
                    if (ce.rd) check("cpu_q", 32'(cpu_q), 32'(ce.d));
                end
            end
            if (mem_we === 1'b1) begin
                if (wrQ.size() == 0) check("mem_we_unexpected", 32'(mem_we), 32'd0);
                else begin
                    we = wrQ.pop_front();
                    check("mem_we_cycle", 32'(cyc), we.cyc);
                    check("mem_a_write", 32'(mem_a), 32'(we.a));
                    check("mem_d_write", 32'(mem_d), 32'(we.d));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int c;
    logic [14:0] bankAddr;
    logic [7:0]  bankData;

    initial begin
        reset = 1'b1; vid_rd = 1'b0; vid_cn = 1'b0; vid_a = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_a = '0; cpu_bank = 1'b0;
        cpu_d = '0; screen_sel = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        monEn = 1'b1;
        check("rst_vid_qv", 32'(vid_qv), 32'd0);
        check("rst_vid_q", 32'(vid_q), 32'd0);
        check("rst_cpu_q", 32'(cpu_q), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_a", 32'(mem_a), 32'd0);
        check("rst_cpu_wait", 32'(cpu_wait), 32'd0);

        // CPU write while idle
        tick(); c = cyc;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a = 14'h1800; cpu_d = 8'hA5;
        wrQ.push_back('{32'(c + 1), 15'h1800, 8'hA5});
        cpuQ.push_back('{32'(c + 2), 1'b0, 8'h00});
        #1 check("wr_wait_pending", 32'(cpu_wait), 32'd1);
        tick();
        tick();
        #1 check("wr_wait_with_ack", 32'(cpu_wait), 32'd0);
        tick(); cpu_req = 1'b0; cpu_wr = 1'b0;

        // CPU read held off by a 6-clock contention window
        tick(); c = cyc;
        vid_cn = 1'b1; cpu_req = 1'b1; cpu_a = 14'h0123;
        cpuQ.push_back('{32'(c + 9), 1'b1, 8'h3C});
        for (int i = 0; i < 6; i++) begin
            #1;
            check("cn_mem_a_held", 32'(mem_a), 32'h1800);
            check("cn_cpu_wait", 32'(cpu_wait), 32'd1);
            tick();
        end
        vid_cn = 1'b0;
        tick();
        #1 check("rd_mem_a", 32'(mem_a), 32'h0123);
        tick(); tick();
        tick(); cpu_req = 1'b0;

        // Back-to-back video fetches
        tick(); c = cyc;
        vid_rd = 1'b1; vid_cn = 1'b1; vid_a = 13'h0020;
        vidQ.push_back('{32'(c + MEM_LAT), 8'h81});
        #1 check("vid_mem_a", 32'(mem_a), 32'h0020);
        tick(); vid_a = 13'h0021;
        vidQ.push_back('{32'(c + 1 + MEM_LAT), 8'h7E});
        tick(); vid_rd = 1'b0; vid_cn = 1'b0;
        tick(); tick();

        // Video read launched while a CPU read is in latency
        tick(); c = cyc;
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_a = 14'h0456;
        cpuQ.push_back('{32'(c + 3), 1'b1, 8'h5A});
        tick();
        tick(); vid_rd = 1'b1; vid_cn = 1'b1; vid_a = 13'h0020;
        vidQ.push_back('{32'(c + 2 + MEM_LAT), 8'h81});
        tick(); vid_rd = 1'b0; vid_cn = 1'b0;
        tick(); cpu_req = 1'b0;
        tick(); tick();

        // Reset asserted in the ACC clock of a write
        tick(); c = cyc;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a = 14'h0222; cpu_d = 8'h99;
        tick(); reset = 1'b1;
        #1 check("rst_acc_mem_we", 32'(mem_we), 32'd0);
        tick(); reset = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
        #1;
        check("rst2_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst2_vid_qv", 32'(vid_qv), 32'd0);
        check("rst2_vid_q", 32'(vid_q), 32'd0);
        check("rst2_cpu_q", 32'(cpu_q), 32'd0);
        check("rst2_mem_a", 32'(mem_a), 32'd0);
        check("rst2_mem_we", 32'(mem_we), 32'd0);
        check("rst2_state", 32'(dut.r_state), 32'(IDLE));
        check("rst2_retry", 32'(dut.r_retryCnt), 32'd0);
        tick(); tick();
        check("rst_write_abandoned", 32'(ram[15'h0222]), 32'd0);

        // Video strobe lands in the ACC clock of a write
        tick(); c = cyc;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a = 14'h0333; cpu_d = 8'h42;
        wrQ.push_back('{32'(c + 2), 15'h0333, 8'h42});
        cpuQ.push_back('{32'(c + 3), 1'b0, 8'h00});
        tick(); vid_rd = 1'b1; vid_cn = 1'b1; vid_a = 13'h0010;
        vidQ.push_back('{32'(c + 1 + MEM_LAT), 8'h66});
        #1;
        check("defer_mem_we", 32'(mem_we), 32'd0);
        check("defer_mem_a", 32'(mem_a), 32'h0010);
        tick(); vid_rd = 1'b0; vid_cn = 1'b0;
        #1;
        check("defer_retry", 32'(dut.r_retryCnt), 32'd1);
        check("defer_wr_mem_a", 32'(mem_a), 32'h0333);
        tick();
        tick(); cpu_req = 1'b0; cpu_wr = 1'b0;

        // Display bank select
`ifdef VRAM_SHADOW_SCREEN_EN
        bankAddr = 15'h4000; bankData = 8'h22;
`else
        bankAddr = 15'h0000; bankData = 8'h11;
`endif
        tick(); c = cyc;
        screen_sel = 1'b1; vid_rd = 1'b1; vid_cn = 1'b1; vid_a = 13'h0000;
        vidQ.push_back('{32'(c + MEM_LAT), bankData});
        #1 check("bank_mem_a", 32'(mem_a), 32'(bankAddr));
        tick(); vid_rd = 1'b0; vid_cn = 1'b0; screen_sel = 1'b0;
        repeat (4) tick();

        check("ram_1800", 32'(ram[15'h1800]), 32'hA5);
        check("ram_0333", 32'(ram[15'h0333]), 32'h42);
        check("vid_pending", 32'(vidQ.size()), 32'd0);
        check("cpu_pending", 32'(cpuQ.size()), 32'd0);
        check("wr_pending", 32'(wrQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single video-RAM port between the display fetch engine and the Z80 bus.
- The display fetch has absolute priority. Its read strobe and contention window arrive straight from the video timing block (rd, cn, a).
- A CPU access to the contended bank is held off while the contention window is open, completed through a request/ack handshake, and reported as a wait level for clock stretching.
- Sits between the video timing block, the CPU bus decoder and the dual-bank video SRAM.

Parameters:
- MEM_LAT, 1, SRAM read latency in clocks (legal values 1 or 2); data valid MEM_LAT clocks after the address is driven.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- vid_rd  in  1  display fetch strobe (from video rd)
- vid_cn  in  1  contention window (from video cn); vid_rd implies vid_cn
- vid_a  in  13  display fetch address
- vid_q  out  8  fetched display byte
- vid_qv  out  1  one-clock pulse, vid_q valid
- cpu_req  in  1  CPU access request; level, held until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_a  in  14  CPU offset within the 16K bank
- cpu_bank  in  1  CPU bank select (shadow screen)
- cpu_d  in  8  CPU write data
- cpu_q  out  8  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-clock completion pulse
- cpu_wait  out  1  cpu_req & ~cpu_ack (combinational)
- screen_sel  in  1  display bank select
- mem_a  out  15  SRAM address {bank, offset}
- mem_we  out  1  SRAM write enable
- mem_d  out  8  SRAM write data
- mem_q  in  8  SRAM read data

Behaviour:
- Reset (synchronous, active-high) sets: state IDLE, cpu_ack 0, vid_qv 0, vid_q 0, cpu_q 0, mem_we 0, mem_a 0, retry counter 0.
  - mem_we is forced 0 in any clock with reset high, so an in-flight CPU write is abandoned, never issued late.
- Video path, every clock with vid_rd=1:
  - mem_a = {vbank, 1'b0, vid_a}; mem_we = 0.
  - A MEM_LAT-deep delay line tags the slot; vid_q <= mem_q and vid_qv pulses MEM_LAT clocks later.
  - Back-to-back vid_rd clocks give back-to-back vid_qv pulses.
- FSM states: IDLE, ACC, WAIT_RD, DONE.
- IDLE:
  - Goes to ACC when cpu_req=1, vid_cn=0, vid_rd=0 and cpu_ack=0 (no re-accept in the ack clock).
  - Otherwise stays in IDLE; cpu_wait stays high while a request is pending.
- ACC:
  - If vid_rd=1: the video slot wins, the CPU drives nothing, stay in ACC, retry counter +1 (4-bit, saturating, diagnostic only).
  - Else: mem_a = {cpu_bank, cpu_a}; mem_we = cpu_wr; mem_d = cpu_d.
  - A write goes to DONE. A read goes to WAIT_RD, or straight to DONE when MEM_LAT=1.
- WAIT_RD: counts the remaining latency clocks, then goes to DONE.
- DONE:
  - For a read, cpu_q <= mem_q.
  - cpu_ack pulses for one clock; go to IDLE.
  - cpu_q holds its value until the next read completes.
- A CPU slot is never started inside vid_cn. A CPU slot already in ACC yields to vid_rd but is not aborted.
- mem_we is high only in an ACC clock with cpu_wr=1 and vid_rd=0.
- Idle bus: mem_a holds its last value; mem_we = 0.
- Read-data collision: when a video read is launched while a CPU read is in latency, the mem_q sample for each is taken at its own tagged slot; the delay-line tags never alias.
- cpu_req dropped before ack: the access still completes and cpu_ack still pulses; the CPU side ignores it.

Optional Feature:
- Macro: VRAM_SHADOW_SCREEN_EN.
- Defined: vbank = screen_sel, and cpu_bank drives mem_a[14], so the display can come from either bank.
- Undefined: mem_a[14] is tied 0 for both requesters; screen_sel and cpu_bank are ignored; a single 16K bank is used.

Decomposition:
- Package vram_pkg holds:
  - the state enum (IDLE, ACC, WAIT_RD, DONE);
  - VRAM_AW=14, VRAM_DW=8, RETRY_W=4;
  - the bank encoding constants.
- One sub-module, vram_rd_tag: the MEM_LAT-deep shift register tagging each read slot as video or CPU, producing the vid_qv and cpu-read-capture strobes.

Test Plan:
- CPU write while idle: cpu_req=1, cpu_wr=1, cpu_a=0x1800, cpu_d=0xA5, vid_cn=0 → mem_we=1 for exactly one clock with mem_a=0x1800 and mem_d=0xA5; cpu_ack one clock later; cpu_wait drops with ack.
- CPU read under contention: vid_cn=1 for 6 clocks, cpu_req raised in clock 0, SRAM holds 0x3C → no mem_a change from CPU until vid_cn=0; cpu_ack with cpu_q=0x3C after 1+MEM_LAT clocks.
- Video fetch, vid_a=0x0020 (SRAM 0x0020=0x81), MEM_LAT=2 → vid_q=0x81 with vid_qv exactly 2 clocks later.
- Video rd during ACC: vid_rd rises in the ACC clock → CPU slot deferred, retry counter=1, write issued next clock, no mem_we in the video clock.
- Reset mid-operation: reset asserted in the ACC clock of a write → no mem_we pulse, no cpu_ack, state IDLE, all outputs at reset values.
- VRAM_SHADOW_SCREEN_EN defined, screen_sel=1, vid_a=0x0000 → mem_a=0x4000. Undefined → mem_a=0x0000.
